multi_grant_arbiter: RTL
========================

// Module: multi_grant_arbiter
// PURPOSE
//   Parametrised successor to the dual-priority encoder. Scans an N-bit request
//   vector and grants up to G requesters per sample. Supports fixed-priority or
//   round-robin search order, and registers all grant outputs.
//   Sits between request sources (switch banks, peripheral IRQ lines) and
//   shared-resource logic that services up to G requesters per cycle.
// PARAMETERS
//   N   12             number of request lines, N >= 2
//   G   2              grant slots per sample, 1 <= G <= N
//   RR  0              0 = fixed priority (index 0 highest); 1 = round-robin
//   W   $clog2(N)      grant index width (derived, do not override)
// PORTS
//   clk       in   1      system clock, all logic on rising edge
//   reset     in   1      synchronous, active-high reset
//   en        in   1      sample strobe; req evaluated only when en=1
//   req       in   N      request vector, bit i = requester i
//   y         out  G*W    packed grant indices, slot k at y[k*W +: W]
//   v         out  G      slot-valid flags, v[k]=1 => slot k holds a grant
//   gnt_mask  out  N      OR of one-hot bits of all granted indices
//   ovf       out  1      1 = more than G requests set; some requests denied
//   ptr       out  W      current round-robin start index (0 when RR=0)
// BEHAVIOUR
//   - Reset: y=0, v=0, gnt_mask=0, ovf=0, ptr=0.
//   - Reset has priority over en.
//   - Reset mid-operation discards the in-flight sample.
//   - Latency: outputs reflect req sampled at the previous edge where en=1.
//   - Latency is exactly 1 cycle.
//   - en=0: y, v, gnt_mask, ovf and ptr all hold their values.
//   - Search order:
//     - RR=0: indices 0,1,...,N-1.
//     - RR=1: ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
//   - Slot filling: the k-th set bit met in search order fills slot k-1.
//     - Filling stops after G slots.
//     - Slots are filled contiguously from slot 0.
//     - Unfilled slots have v[k]=0 and y slot = 0.
//   - gnt_mask has exactly popcount(v) bits set, each matching one valid y slot.
//   - ovf = (popcount(req) > G), registered with the grants.
//   - Pointer update (RR=1, en=1):
//     - If at least one grant: ptr <= (index in the highest valid slot + 1) mod N.
//     - If req=0: ptr unchanged.
//     - Index N-1 granted last => ptr wraps to 0.
//   - RR=0: ptr is held at 0.
//   - No state machine beyond ptr. A single req bit gives v = one-hot slot 0.
//   - All index arithmetic is modulo N. N need not be a power of two.
//   - No y slot may ever hold a value >= N.
// TESTING
//   - Reset: reset=1, en=1, req=12'hFFF -> next cycle y=0, v=0, gnt_mask=0,
//     ovf=0, ptr=0.
//   - RR=0: req=12'h0A0, en=1 -> y0=5, y1=7, v=2'b11, gnt_mask=12'h0A0, ovf=0.
//   - RR=0: req=12'hFFF -> y0=0, y1=1, v=2'b11, gnt_mask=12'h003, ovf=1.
//     Then req=12'h800 -> y0=11, v=2'b01, y1=0.
//   - RR=1, req=12'hFFF, en held high for 7 cycles -> pairs (0,1),(2,3),(4,5),
//     (6,7),(8,9),(10,11),(0,1); ptr wraps 10 -> 0.
//   - RR=1, ptr=10, req=12'h804 -> y0=11, y1=2, v=2'b11, ptr->3.
//     Then req=0 -> v=0, ptr stays 3.
//   - Hold and reset priority: en=0 while req toggles -> outputs frozen.
//     reset and en asserted together -> reset values.
//     G=1 build, req=12'h0C0 -> y0=6, ovf=1.

Source files
------------

// File: rtl/multi_grant_arbiter.sv
// Multi-grant arbiter: grants up to G of N requesters per enabled sample, in
// fixed-priority or round-robin order, with all outputs registered.
module multi_grant_arbiter #(
  parameter int N  = 12,
  parameter int G  = 2,
  parameter int RR = 0,
  parameter int W  = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [G*W-1:0] y,
  output logic [G-1:0]   v,
  output logic [N-1:0]   gnt_mask,
  output logic           ovf,
  output logic [W-1:0]   ptr
);

  logic [G*W-1:0] r_y;
  logic [G-1:0]   r_v;
  logic [N-1:0]   r_mask;
  logic           r_ovf;
  logic [W-1:0]   r_ptr;

  logic [G*W-1:0] w_y;
  logic [G-1:0]   w_v;
  logic [N-1:0]   w_mask;
  logic           w_ovf;
  logic [W-1:0]   w_last;
  logic [W-1:0]   w_ptr_nxt;
  int             w_cnt;
  int             w_pop;
  int             w_idx;

  // Walk all N positions starting at the search origin; the k-th request met
  // lands in slot k, and every request met contributes to the overflow count.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_y    = '0;
    w_v    = '0;
    w_mask = '0;
    w_last = '0;
    w_cnt  = 0;
    w_pop  = 0;
    w_idx  = 0;
    for (int j = 0; j < N; j++) begin
      w_idx = ((RR != 0) ? int'(r_ptr) : 0) + j;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) begin
        w_pop = w_pop + 1;
        if (w_cnt < G) begin
          w_y[w_cnt*W +: W] = W'(w_idx);
          w_v[w_cnt]        = 1'b1;
          w_mask[w_idx]     = 1'b1;
          w_last            = W'(w_idx);
          w_cnt             = w_cnt + 1;
        end
      end
    end
    w_ovf = (w_pop > G);
  end

  // Next origin is one past the last granted index, wrapping at N (N need
  // not be a power of two, so the wrap is explicit).
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (RR == 0) begin
      w_ptr_nxt = '0;
    end else if (|req) begin
      w_ptr_nxt = (int'(w_last) == N - 1) ? '0 : w_last + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_y    <= '0;
      r_v    <= '0;
      r_mask <= '0;
      r_ovf  <= 1'b0;
      r_ptr  <= '0;
    end else if (en) begin
      r_y    <= w_y;
      r_v    <= w_v;
      r_mask <= w_mask;
      r_ovf  <= w_ovf;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign y        = r_y;
  assign v        = r_v;
  assign gnt_mask = r_mask;
  assign ovf      = r_ovf;
  assign ptr      = r_ptr;

endmodule
